// File: rtl/rsa_pkg.sv
// Shared types and mux-select encodings for the RSA exponentiation sequencer.
// RSA_EXP_SKIP_LZ_EN adds the leading-zero skip state.
package rsa_pkg;

  // Operand mux select encodings (X: a=ACC b=MSG, Y: a=ACC b=BASE)
  localparam logic [1:0] MUX_SEL_A    = 2'b00;
  localparam logic [1:0] MUX_SEL_B    = 2'b01;
  localparam logic [1:0] MUX_SEL_ONE  = 2'b10;
  localparam logic [1:0] MUX_SEL_ZERO = 2'b11;

  typedef enum logic [3:0] {
    StIdle,
    StLoad,
    StPreBase,
    StPreAcc,
    StSqr,
    StMul,
    StNext,
    StPost,
    StDone
`ifdef RSA_EXP_SKIP_LZ_EN
    ,
    StSkip
`endif
  } state_e;

  // States that drive one multiplier operation (ISSUE then WAIT phase)
  function automatic logic is_op_state(state_e s);
    return (s == StPreBase) || (s == StPreAcc) || (s == StSqr) || (s == StMul) ||
           (s == StPost);
  endfunction

endpackage

// File: rtl/rsa_exp_ctrl_if.sv
// Control bundle between the exponentiation sequencer (master) and the
// Montgomery multiplier datapath (slave).
interface rsa_exp_ctrl_if;
  logic       mm_start;
  logic       mm_done;
  logic [1:0] x_sel;
  logic [1:0] y_sel;
  logic       acc_ld_r2;
  logic       acc_we;
  logic       base_we;

  modport master (
    output mm_start,
    output x_sel,
    output y_sel,
    output acc_ld_r2,
    output acc_we,
    output base_we,
    input  mm_done
  );

  modport slave (
    input  mm_start,
    input  x_sel,
    input  y_sel,
    input  acc_ld_r2,
    input  acc_we,
    input  base_we,
    output mm_done
  );
endinterface

// File: rtl/rsa_bit_cnt.sv
// Exponent bit-index down-counter: parallel load, saturating decrement, zero flag.
module rsa_bit_cnt #(
  parameter int unsigned CntW = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_i,
  input  logic [CntW-1:0] load_val_i,
  input  logic            dec_i,
  output logic [CntW-1:0] cnt_o,
  output logic            is_zero_o
);

  logic [CntW-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o     = cnt_q;
  assign is_zero_o = (cnt_q == '0);

endmodule

// File: rtl/rsa_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer driving a shared Montgomery multiplier.
// Define RSA_EXP_SKIP_LZ_EN to skip leading zero exponent bits without squaring.
module rsa_exp_ctrl
  import rsa_pkg::*;
#(
  parameter int unsigned EXP_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [EXP_WIDTH-1:0] exp,
  output logic                 busy,
  output logic                 done,
  rsa_exp_ctrl_if.master       mm
);

  localparam int unsigned CNT_W = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;

  state_e               state_d, state_q;
  logic                 wait_d, wait_q;
  logic [EXP_WIDTH-1:0] exp_d, exp_q;

  logic             cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0] bit_idx;
  logic             op_done;

  rsa_bit_cnt #(
    .CntW(CNT_W)
  ) u_bit_cnt (
    .clk       (clk),
    .rst       (rst),
    .load_i    (cnt_load),
    .load_val_i(CNT_W'(EXP_WIDTH - 1)),
    .dec_i     (cnt_dec),
    .cnt_o     (bit_idx),
    .is_zero_o (cnt_zero)
  );

  // A multiplier result is only meaningful while an op state is in its WAIT phase
  assign op_done = wait_q & mm.mm_done;

  always_comb begin
    state_d      = state_q;
    wait_d       = 1'b0;
    exp_d        = exp_q;
    cnt_load     = 1'b0;
    cnt_dec      = 1'b0;
    mm.x_sel     = MUX_SEL_ZERO;
    mm.y_sel     = MUX_SEL_ZERO;
    mm.mm_start  = 1'b0;
    mm.acc_ld_r2 = 1'b0;
    mm.acc_we    = 1'b0;
    mm.base_we   = 1'b0;
    busy         = 1'b1;
    done         = 1'b0;

    unique case (state_q)
      StIdle: begin
        busy = 1'b0;
        if (start) begin
          exp_d    = exp;
          cnt_load = 1'b1;
          state_d  = StLoad;
        end
      end
      StLoad: begin
        mm.acc_ld_r2 = 1'b1;
        state_d      = StPreBase;
      end
      StPreBase: begin
        mm.x_sel   = MUX_SEL_B;
        mm.y_sel   = MUX_SEL_A;
        mm.base_we = op_done;
        if (op_done) state_d = StPreAcc;
      end
      StPreAcc: begin
        mm.x_sel  = MUX_SEL_ONE;
        mm.y_sel  = MUX_SEL_A;
        mm.acc_we = op_done;
`ifdef RSA_EXP_SKIP_LZ_EN
        if (op_done) state_d = StSkip;
`else
        if (op_done) state_d = StSqr;
`endif
      end
      StSqr: begin
        mm.x_sel  = MUX_SEL_A;
        mm.y_sel  = MUX_SEL_A;
        mm.acc_we = op_done;
        if (op_done) state_d = exp_q[bit_idx] ? StMul : StNext;
      end
      StMul: begin
        mm.x_sel  = MUX_SEL_A;
        mm.y_sel  = MUX_SEL_B;
        mm.acc_we = op_done;
        if (op_done) state_d = StNext;
      end
      StNext: begin
        if (cnt_zero) begin
          state_d = StPost;
        end else begin
          cnt_dec = 1'b1;
          state_d = StSqr;
        end
      end
`ifdef RSA_EXP_SKIP_LZ_EN
      StSkip: begin
        if (exp_q[bit_idx]) begin
          state_d = StSqr;
        end else if (cnt_zero) begin
          state_d = StPost;
        end else begin
          cnt_dec = 1'b1;
        end
      end
`endif
      StPost: begin
        mm.x_sel  = MUX_SEL_A;
        mm.y_sel  = MUX_SEL_ONE;
        mm.acc_we = op_done;
        if (op_done) state_d = StDone;
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Shared ISSUE/WAIT sequencing for every multiplier op state
    if (is_op_state(state_q)) begin
      mm.mm_start = ~wait_q;
      wait_d      = ~op_done;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      wait_q  <= 1'b0;
      exp_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      exp_q   <= exp_d;
    end
  end

endmodule
